// File: rtl/processador.sv
// Single-cycle RV32I-subset core: instruction memory, register file, data
// memory, ALU and control. One instruction commits per rising clock edge.

module processador_mem_instrucoes (
    input  logic [31:0] endereco_i,
    output logic [31:0] instrucao_o
);
    logic [31:0] memoria_instrucoes [0:31];
    logic        unused_end_s;

    assign unused_end_s = ^{endereco_i[31:7], endereco_i[1:0]};

    // Combinational fetch; the index wraps within the 32 words
    always_comb begin
        instrucao_o = memoria_instrucoes[endereco_i[6:2]];
    end
endmodule

module processador_registradores (
    input  logic        clock,
    input  logic        escreve_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [4:0]  rd_i,
    input  logic [31:0] dado_i,
    output logic [31:0] dado1_o,
    output logic [31:0] dado2_o
);
    logic [31:0] registradores [0:31];

    // Two read ports; x0 is hard-wired to zero regardless of storage contents
    always_comb begin
        dado1_o = (rs1_i == 5'd0) ? 32'd0 : registradores[rs1_i];
        dado2_o = (rs2_i == 5'd0) ? 32'd0 : registradores[rs2_i];
    end

    // Single write port; writes aimed at x0 are dropped
    always_ff @(posedge clock) begin
        if (escreve_i && (rd_i != 5'd0)) begin
            registradores[rd_i] <= dado_i;
        end
    end
endmodule

module processador_memoria_dados (
    input  logic        clock,
    input  logic        escreve_i,
    input  logic [31:0] endereco_i,
    input  logic [31:0] dado_i,
    output logic [31:0] dado_o
);
    logic [31:0] memoria_dados [0:31];
    logic        unused_end_s;

    assign unused_end_s = ^{endereco_i[31:7], endereco_i[1:0]};

    // Combinational load; low address bits are ignored
    always_comb begin
        dado_o = memoria_dados[endereco_i[6:2]];
    end

    // Word store on the rising edge
    always_ff @(posedge clock) begin
        if (escreve_i) begin
            memoria_dados[endereco_i[6:2]] <= dado_i;
        end
    end
endmodule

module processador_alu (
    input  logic [31:0] valor1,
    input  logic [31:0] valor2,
    input  logic [3:0]  resultado_alu_control,
    input  logic        eh_beq_i,
    input  logic        eh_bne_i,
    output logic [31:0] resultado_alu,
    output logic        resultado_desvio
);
    // Arithmetic/logic result selected by the 4-bit control code
    always_comb begin
        resultado_alu = 32'd0;
        case (resultado_alu_control)
            4'b0000: resultado_alu = valor1 & valor2;
            4'b0001: resultado_alu = valor1 | valor2;
            4'b0010: resultado_alu = valor1 + valor2;
            4'b0011: resultado_alu = valor1 ^ valor2;
            4'b0100: resultado_alu = valor1 << valor2[4:0];
            4'b0101: resultado_alu = valor1 >> valor2[4:0];
            4'b0110: resultado_alu = valor1 - valor2;
            4'b0111: resultado_alu = {31'd0, ($signed(valor1) < $signed(valor2))};
            default: resultado_alu = 32'd0;
        endcase
    end

    // Branch condition from the SUB result; zero for non-branch instructions
    always_comb begin
        if (eh_beq_i) begin
            resultado_desvio = (resultado_alu == 32'd0);
        end else if (eh_bne_i) begin
            resultado_desvio = (resultado_alu != 32'd0);
        end else begin
            resultado_desvio = 1'b0;
        end
    end
endmodule

module processador (
    input  logic clock,
    input  logic reset
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SLL = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    logic [31:0] pc_q, pc_d;
    logic [31:0] instrucao_saida;
    logic [31:0] rs1_dado_s, rs2_dado_s, mem_dado_s, wb_dado_s;
    logic [31:0] imm_s, valor2_s, alu_res_s;
    logic [3:0]  alu_ctrl_s;
    logic        reg_we_s, mem_we_s, usa_imm_s, mem_para_reg_s;
    logic        eh_beq_s, eh_bne_s, desvio_s;

    logic [6:0]  opcode_s, funct7_s;
    logic [2:0]  funct3_s;

    assign opcode_s = instrucao_saida[6:0];
    assign funct3_s = instrucao_saida[14:12];
    assign funct7_s = instrucao_saida[31:25];

    processador_mem_instrucoes mem_inst (
        .endereco_i  (pc_q),
        .instrucao_o (instrucao_saida)
    );

    // Writes are suppressed while reset is held so only the PC changes
    processador_registradores reg_inst (
        .clock     (clock),
        .escreve_i (reg_we_s & ~reset),
        .rs1_i     (instrucao_saida[19:15]),
        .rs2_i     (instrucao_saida[24:20]),
        .rd_i      (instrucao_saida[11:7]),
        .dado_i    (wb_dado_s),
        .dado1_o   (rs1_dado_s),
        .dado2_o   (rs2_dado_s)
    );

    processador_memoria_dados memdados_inst (
        .clock      (clock),
        .escreve_i  (mem_we_s & ~reset),
        .endereco_i (alu_res_s),
        .dado_i     (rs2_dado_s),
        .dado_o     (mem_dado_s)
    );

    processador_alu alu_inst (
        .valor1                (rs1_dado_s),
        .valor2                (valor2_s),
        .resultado_alu_control (alu_ctrl_s),
        .eh_beq_i              (eh_beq_s),
        .eh_bne_i              (eh_bne_s),
        .resultado_alu         (alu_res_s),
        .resultado_desvio      (desvio_s)
    );

    // Decode: immediate format, ALU operation and write enables; anything unknown is a NOP
    always_comb begin
        reg_we_s       = 1'b0;
        mem_we_s       = 1'b0;
        usa_imm_s      = 1'b0;
        mem_para_reg_s = 1'b0;
        eh_beq_s       = 1'b0;
        eh_bne_s       = 1'b0;
        alu_ctrl_s     = ALU_ADD;
        imm_s          = 32'd0;
        case (opcode_s)
            OP_R: begin
                reg_we_s = 1'b1;
                case ({funct7_s, funct3_s})
                    {7'b0000000, 3'b000}: alu_ctrl_s = ALU_ADD;
                    {7'b0100000, 3'b000}: alu_ctrl_s = ALU_SUB;
                    {7'b0000000, 3'b111}: alu_ctrl_s = ALU_AND;
                    {7'b0000000, 3'b110}: alu_ctrl_s = ALU_OR;
                    {7'b0000000, 3'b100}: alu_ctrl_s = ALU_XOR;
                    {7'b0000000, 3'b001}: alu_ctrl_s = ALU_SLL;
                    {7'b0000000, 3'b101}: alu_ctrl_s = ALU_SRL;
                    {7'b0000000, 3'b010}: alu_ctrl_s = ALU_SLT;
                    default:              reg_we_s   = 1'b0;
                endcase
            end
            OP_I: begin
                reg_we_s  = 1'b1;
                usa_imm_s = 1'b1;
                imm_s     = {{20{instrucao_saida[31]}}, instrucao_saida[31:20]};
                case (funct3_s)
                    3'b000:  alu_ctrl_s = ALU_ADD;
                    3'b111:  alu_ctrl_s = ALU_AND;
                    3'b110:  alu_ctrl_s = ALU_OR;
                    3'b100:  alu_ctrl_s = ALU_XOR;
                    3'b010:  alu_ctrl_s = ALU_SLT;
                    default: reg_we_s   = 1'b0;
                endcase
            end
            OP_LW: begin
                reg_we_s       = 1'b1;
                usa_imm_s      = 1'b1;
                mem_para_reg_s = 1'b1;
                imm_s          = {{20{instrucao_saida[31]}}, instrucao_saida[31:20]};
            end
            OP_SW: begin
                mem_we_s  = 1'b1;
                usa_imm_s = 1'b1;
                imm_s     = {{20{instrucao_saida[31]}}, instrucao_saida[31:25],
                             instrucao_saida[11:7]};
            end
            OP_BRANCH: begin
                alu_ctrl_s = ALU_SUB;
                imm_s      = {{19{instrucao_saida[31]}}, instrucao_saida[31],
                              instrucao_saida[7], instrucao_saida[30:25],
                              instrucao_saida[11:8], 1'b0};
                case (funct3_s)
                    3'b000:  eh_beq_s = 1'b1;
                    3'b001:  eh_bne_s = 1'b1;
                    default: eh_beq_s = 1'b0;
                endcase
            end
            default: reg_we_s = 1'b0;
        endcase
    end

    // Operand and writeback muxes
    always_comb begin
        valor2_s  = usa_imm_s ? imm_s : rs2_dado_s;
        wb_dado_s = mem_para_reg_s ? mem_dado_s : alu_res_s;
    end

    // Next PC: taken branch adds the byte offset, otherwise fall through
    always_comb begin
        if ((eh_beq_s || eh_bne_s) && desvio_s) begin
            pc_d = pc_q + imm_s;
        end else begin
            pc_d = pc_q + 32'd4;
        end
    end

    // Program counter with synchronous reset to address 0
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q <= 32'd0;
        end else begin
            pc_q <= pc_d;
        end
    end
endmodule

// File: tb/tb_processador.sv
// Directed bench for processador: preloads storage by hierarchy, steps one
// instruction per clock and compares against hand-computed values.

module tb_processador;
    logic clock;
    logic reset;
    int   n_checks;
    int   n_pass;

    processador dut (
        .clock (clock),
        .reset (reset)
    );

    always #1 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    logic [31:0] prog1 [6];
    logic [31:0] prog2 [16];
    logic [31:0] instr_v;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        clock    = 1'b0;
        reset    = 1'b1;

        prog1[0] = 32'h00500093; // addi x1,x0,5
        prog1[1] = 32'h00300113; // addi x2,x0,3
        prog1[2] = 32'h002081B3; // add  x3,x1,x2
        prog1[3] = 32'h00000463; // beq  x0,x0,+8
        prog1[4] = 32'h00100313; // addi x6,x0,1 (skipped)
        prog1[5] = 32'h00302023; // sw   x3,0(x0)

        prog2[0]  = 32'h402082B3; // sub  x5,x1,x2
        prog2[1]  = 32'h00002203; // lw   x4,0(x0)
        prog2[2]  = 32'h004203B3; // add  x7,x4,x4
        prog2[3]  = 32'h00700013; // addi x0,x0,7
        prog2[4]  = 32'h00001463; // bne  x0,x0,+8 (not taken)
        prog2[5]  = 32'h00209463; // bne  x1,x2,+8 (taken)
        prog2[6]  = 32'h00100313; // addi x6,x0,1 (skipped)
        prog2[7]  = 32'h00112433; // slt  x8,x2,x1
        prog2[8]  = 32'hFFF00493; // addi x9,x0,-1
        prog2[9]  = 32'h0004A533; // slt  x10,x9,x0
        prog2[10] = 32'h0014D5B3; // srl  x11,x9,x1
        prog2[11] = 32'h00111633; // sll  x12,x2,x1
        prog2[12] = 32'h00902223; // sw   x9,4(x0)
        prog2[13] = 32'h0F04F693; // andi x13,x9,0xF0
        prog2[14] = 32'h0020C733; // xor  x14,x1,x2
        prog2[15] = 32'hFE000CE3; // beq  x0,x0,-8

        for (int i = 0; i < 32; i++) dut.reg_inst.registradores[i] = 32'd0;
        for (int i = 0; i < 5; i++) dut.memdados_inst.memoria_dados[i] = 32'hA0 + i;
        for (int i = 0; i < 6; i++) dut.mem_inst.memoria_instrucoes[i] = prog1[i];

        // Reset held 5 cycles: PC stays 0 and the addi at 0 must not commit
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("rst_pc", dut.pc_q, 32'd0);
        end
        check_eq("rst_x1_unwritten", dut.reg_inst.registradores[1], 32'd0);
        reset = 1'b0;

        check_eq("fetch_instr", dut.instrucao_saida, 32'h00500093);
        check_eq("addi_alu", dut.alu_inst.resultado_alu, 32'h5);
        check_eq("addi_ctrl", {28'd0, dut.alu_inst.resultado_alu_control}, 32'h2);
        tick();
        check_eq("addi_x1", dut.reg_inst.registradores[1], 32'd5);
        check_eq("pc_4", dut.pc_q, 32'h4);
        tick();
        check_eq("addi_x2", dut.reg_inst.registradores[2], 32'd3);
        check_eq("add_ctrl", {28'd0, dut.alu_inst.resultado_alu_control}, 32'h2);
        check_eq("add_alu", dut.alu_inst.resultado_alu, 32'd8);
        tick();
        check_eq("add_x3", dut.reg_inst.registradores[3], 32'd8);
        check_eq("beq_pc", dut.pc_q, 32'h0C);
        check_eq("beq_desvio", {31'd0, dut.alu_inst.resultado_desvio}, 32'd1);
        tick();
        check_eq("beq_target", dut.pc_q, 32'h14);
        check_eq("sw_alu_addr", dut.alu_inst.resultado_alu, 32'd0);
        tick();
        check_eq("sw_mem0", dut.memdados_inst.memoria_dados[0], 32'd8);
        check_eq("eop_pc", dut.pc_q, 32'h18);
        instr_v = dut.instrucao_saida;
        check_eq("eop_instr_unloaded", {31'd0, ($isunknown(instr_v) || (instr_v == 32'd0))}, 32'd1);
        repeat (4) tick();
        check_eq("eop_x1", dut.reg_inst.registradores[1], 32'd5);
        check_eq("eop_x2", dut.reg_inst.registradores[2], 32'd3);
        check_eq("eop_x3", dut.reg_inst.registradores[3], 32'd8);
        check_eq("eop_x4", dut.reg_inst.registradores[4], 32'd0);
        check_eq("eop_x6_skipped", dut.reg_inst.registradores[6], 32'd0);
        check_eq("eop_mem0", dut.memdados_inst.memoria_dados[0], 32'd8);
        for (int i = 1; i < 5; i++) begin
            check_eq("eop_mem_keep", dut.memdados_inst.memoria_dados[i], 32'hA0 + i);
        end

        // Mid-program reset: restart at 0 with a new program, state retained
        reset = 1'b1;
        for (int i = 0; i < 16; i++) dut.mem_inst.memoria_instrucoes[i] = prog2[i];
        tick();
        check_eq("rst2_pc", dut.pc_q, 32'd0);
        check_eq("rst2_x3_kept", dut.reg_inst.registradores[3], 32'd8);
        reset = 1'b0;

        check_eq("sub_ctrl", {28'd0, dut.alu_inst.resultado_alu_control}, 32'h6);
        check_eq("sub_alu", dut.alu_inst.resultado_alu, 32'd2);
        tick();
        check_eq("sub_x5", dut.reg_inst.registradores[5], 32'd2);
        tick();
        check_eq("lw_x4", dut.reg_inst.registradores[4], 32'd8);
        check_eq("lw_use_alu", dut.alu_inst.resultado_alu, 32'd16);
        tick();
        check_eq("lw_use_x7", dut.reg_inst.registradores[7], 32'd16);
        check_eq("x0_alu", dut.alu_inst.resultado_alu, 32'd7);
        tick();
        check_eq("x0_kept", dut.reg_inst.registradores[0], 32'd0);
        check_eq("bne_eq_desvio", {31'd0, dut.alu_inst.resultado_desvio}, 32'd0);
        tick();
        check_eq("bne_eq_pc", dut.pc_q, 32'h14);
        check_eq("bne_ne_desvio", {31'd0, dut.alu_inst.resultado_desvio}, 32'd1);
        tick();
        check_eq("bne_ne_pc", dut.pc_q, 32'h1C);
        check_eq("slt_ctrl", {28'd0, dut.alu_inst.resultado_alu_control}, 32'h7);
        tick();
        check_eq("slt_x8", dut.reg_inst.registradores[8], 32'd1);
        check_eq("bne_skip_x6", dut.reg_inst.registradores[6], 32'd0);
        tick();
        check_eq("addi_neg_x9", dut.reg_inst.registradores[9], 32'hFFFFFFFF);
        tick();
        check_eq("slt_signed_x10", dut.reg_inst.registradores[10], 32'd1);
        tick();
        check_eq("srl_x11", dut.reg_inst.registradores[11], 32'h07FFFFFF);
        tick();
        check_eq("sll_x12", dut.reg_inst.registradores[12], 32'h60);
        check_eq("sw4_alu", dut.alu_inst.resultado_alu, 32'd4);
        tick();
        check_eq("sw4_mem1", dut.memdados_inst.memoria_dados[1], 32'hFFFFFFFF);
        tick();
        check_eq("andi_x13", dut.reg_inst.registradores[13], 32'hF0);
        tick();
        check_eq("xor_x14", dut.reg_inst.registradores[14], 32'd6);
        check_eq("beq_back_desvio", {31'd0, dut.alu_inst.resultado_desvio}, 32'd1);
        tick();
        check_eq("beq_back_pc", dut.pc_q, 32'h34);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
